// File: rtl/intersection_ctrl.sv
// intersection_ctrl: two-road traffic-light sequencer.
// A Moore FSM steps through the main-green / side-green / pedestrian phases.
// A 4-bit per-phase timer advances only on the tick timebase. Side-road and
// pedestrian requests are latched until they are served.
module intersection_ctrl #(
    parameter int unsigned MAIN_GREEN = 4,
    parameter int unsigned SIDE_GREEN = 3,
    parameter int unsigned AMBER      = 2,
    parameter int unsigned ALL_RED    = 1,
    parameter int unsigned WALK       = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       side_car,
    input  logic       ped_btn,
    output logic [1:0] light_main,
    output logic [1:0] light_side,
    output logic [3:0] countdown,
    output logic       side_pend,
    output logic       ped_pend
);

    // Light codes shared by both roads
    localparam logic [1:0] LT_RED   = 2'b00;
    localparam logic [1:0] LT_GREEN = 2'b01;
    localparam logic [1:0] LT_AMBER = 2'b10;
    localparam logic [1:0] LT_WALK  = 2'b11;

    // A zero duration would never expire cleanly, so force it to one tick;
    // anything above the 4-bit timer range saturates at 15.
    function automatic logic [3:0] clamp_dur(input int unsigned v);
        logic [3:0] r;
        if (v == 0)
            r = 4'd1;
        else if (v > 15)
            r = 4'd15;
        else
            r = v[3:0];
        return r;
    endfunction

    localparam logic [3:0] T_MAIN_GREEN = clamp_dur(MAIN_GREEN);
    localparam logic [3:0] T_SIDE_GREEN = clamp_dur(SIDE_GREEN);
    localparam logic [3:0] T_AMBER      = clamp_dur(AMBER);
    localparam logic [3:0] T_ALL_RED    = clamp_dur(ALL_RED);
    localparam logic [3:0] T_WALK       = clamp_dur(WALK);

    typedef enum logic [2:0] {
        M_GRN = 3'd0,
        M_AMB = 3'd1,
        RED_A = 3'd2,
        S_GRN = 3'd3,
        S_AMB = 3'd4,
        PED   = 3'd5,
        RED_B = 3'd6
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] timer;
    logic [3:0] timer_next;
    logic       side_pend_next;
    logic       ped_pend_next;
    logic       enter_s_grn;
    logic       enter_ped;

    // Duration loaded into the timer on entry to a phase
    function automatic logic [3:0] phase_dur(input state_t s);
        logic [3:0] d;
        case (s)
            M_GRN:   d = T_MAIN_GREEN;
            M_AMB:   d = T_AMBER;
            S_AMB:   d = T_AMBER;
            RED_A:   d = T_ALL_RED;
            RED_B:   d = T_ALL_RED;
            S_GRN:   d = T_SIDE_GREEN;
            PED:     d = T_WALK;
            default: d = T_ALL_RED;
        endcase
        return d;
    endfunction

    // State, timer and request latches; reset parks the FSM in the all-red clearance
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RED_B;
            timer     <= T_ALL_RED;
            side_pend <= 1'b0;
            ped_pend  <= 1'b0;
        end else begin
            state     <= state_next;
            timer     <= timer_next;
            side_pend <= side_pend_next;
            ped_pend  <= ped_pend_next;
        end
    end

    // Next-state and timer: count down on tick, change phase when the last tick expires
    always_comb begin
        state_next = state;
        timer_next = timer;
        if (tick) begin
            if (timer > 4'd1) begin
                timer_next = timer - 4'd1;
            end else begin
                case (state)
                    M_GRN: begin
                        if (side_pend || ped_pend)
                            state_next = M_AMB;
                        else
                            state_next = M_GRN;
                    end
                    M_AMB:   state_next = RED_A;
                    RED_A:   state_next = ped_pend ? PED : S_GRN;
                    S_GRN:   state_next = S_AMB;
                    S_AMB:   state_next = RED_B;
                    PED:     state_next = RED_B;
                    RED_B:   state_next = M_GRN;
                    default: state_next = RED_B;
                endcase
                // Main green with nothing waiting stays at one tick and re-checks every tick
                if (state == M_GRN && state_next == M_GRN)
                    timer_next = 4'd1;
                else
                    timer_next = phase_dur(state_next);
            end
        end
    end

    // Request latches: any high input cycle sets, entering the serving phase clears (clear wins)
    always_comb begin
        enter_s_grn    = (state_next == S_GRN) && (state != S_GRN);
        enter_ped      = (state_next == PED) && (state != PED);
        side_pend_next = enter_s_grn ? 1'b0 : (side_pend | side_car);
        ped_pend_next  = enter_ped   ? 1'b0 : (ped_pend  | ped_btn);
    end

    // Light decode from the registered state only
    always_comb begin
        light_main = LT_RED;
        light_side = LT_RED;
        case (state)
            M_GRN: light_main = LT_GREEN;
            M_AMB: light_main = LT_AMBER;
            S_GRN: light_side = LT_GREEN;
            S_AMB: light_side = LT_AMBER;
            PED: begin
                light_main = LT_WALK;
                light_side = LT_WALK;
            end
            default: begin
                light_main = LT_RED;
                light_side = LT_RED;
            end
        endcase
    end

    assign countdown = timer;

endmodule

// File: doc/intersection_ctrl.md
# intersection_ctrl

Two-road traffic-intersection sequencer producing the 2-bit light codes that the seven-segment light decoders display for the main road and the side road. A Moore state machine with a per-phase tick-driven countdown serves latched side-road car and pedestrian requests. It holds main-road green by default and never shows green on both roads at once.

## Interface
- MAIN_GREEN, 4: minimum main-road green, in ticks (1..15)
- SIDE_GREEN, 3: side-road green, in ticks (1..15)
- AMBER, 2: amber duration for either road, in ticks (1..15)
- ALL_RED, 1: all-red clearance, in ticks (1..15)
- WALK, 3: pedestrian walk phase, in ticks (1..15)
- clk  in  1  system clock; all logic on the rising edge
- rst_n  in  1  synchronous active-low reset
- tick  in  1  one-cycle timebase enable (e.g. 1 Hz strobe); the timer advances only on tick
- side_car  in  1  side-road vehicle sensor; any high cycle latches a request
- ped_btn  in  1  pedestrian button; any high cycle latches a request
- light_main  out  2  main-road code: 00 RED, 01 GREEN, 10 AMBER, 11 WALK (vehicles held, pedestrians cross)
- light_side  out  2  side-road code, same encoding
- countdown  out  4  ticks remaining in the current phase (timer value)
- side_pend  out  1  latched side-road request
- ped_pend  out  1  latched pedestrian request

## Operation
- States and outputs (main/side):
  - M_GRN 01/00
  - M_AMB 10/00
  - RED_A 00/00
  - S_GRN 00/01
  - S_AMB 00/10
  - PED 11/11
  - RED_B 00/00
- On entry to each state, the 4-bit timer loads that state's duration parameter:
  - M_GRN=MAIN_GREEN, M_AMB=AMBER, S_AMB=AMBER, RED_A=ALL_RED, RED_B=ALL_RED, S_GRN=SIDE_GREEN, PED=WALK.
- On a tick cycle with timer>1, the timer decrements. On a tick cycle with timer==1, the phase expires and the transition below happens.
- Transitions on expiry:
  - M_GRN: if side_pend or ped_pend, go to M_AMB. Otherwise stay in M_GRN with the timer held at 1, re-evaluated on every subsequent tick.
  - M_AMB → RED_A.
  - RED_A: if ped_pend, go to PED; otherwise go to S_GRN. Pedestrian has priority.
  - S_GRN → S_AMB, then S_AMB → RED_B.
  - PED → RED_B.
  - RED_B → M_GRN.
- Request latches:
  - side_pend sets on side_car=1 and clears on the clock edge entering S_GRN.
  - ped_pend sets on ped_btn=1 and clears on the edge entering PED.
  - Clear wins over set in the same cycle.
  - Requests arriving during S_GRN/PED set the latch normally and are served on the next main-green expiry.
- A side request left pending after PED is served on the next main-green expiry.
- Parameter value 0 is illegal. The implementation clamps it to 1.

## Timing
- Reset is sampled on a clk edge with rst_n=0. It overrides tick and all requests, and works mid-phase. After the edge:
  - state=RED_B, timer=ALL_RED
  - light_main=00, light_side=00, countdown=ALL_RED
  - side_pend=0, ped_pend=0
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- Latency:
  - A request latch is visible the cycle after the input goes high.
  - A state change is visible the cycle after the expiring tick.
- With tick=0, state, timer and outputs hold indefinitely. Latches still capture requests.
- Every phase lasts exactly its parameter count of ticks. M_GRN lasts at least MAIN_GREEN ticks.
- Safety invariant: light_main and light_side are never both in {01,10}.

## Test plan
- **Idle after reset.** Defaults, tick every cycle, no requests, reset released → RED_B for 1 cycle (00/00, countdown 1), then M_GRN with countdown 4,3,2,1. Holds 01/00 with countdown 1 indefinitely.
- **Side-road service.** side_car pulsed one cycle during M_GRN, tick every cycle → M_GRN ends after 4 ticks. Then:
  - 10/00 ×2
  - 00/00 ×1
  - 00/01 ×3 (side_pend drops on entry)
  - 00/10 ×2
  - 00/00 ×1
  - back to 01/00
- **Ped and side together.** ped_btn and side_car in the same cycle during M_GRN → M_AMB, RED_A, then PED 11/11 ×3 with ped_pend cleared. Then RED_B and M_GRN with side_pend still 1. After 4 more ticks, the side cycle runs.
- **Tick gating.** In M_GRN at countdown 3, hold tick=0 for 20 cycles → countdown stays 3 and outputs unchanged. A ped_btn pulse meanwhile sets ped_pend=1.
- **Reset mid-phase.** rst_n=0 for one edge while in S_GRN with countdown 2 → next cycle 00/00, countdown 1, both pend flags 0. Normal sequence then resumes through M_GRN.
- **Invariant and clear-wins.** Random side_car/ped_btn/tick for 10k cycles → no cycle with both roads in {01,10}. A ped_btn asserted on the edge entering PED leaves ped_pend=0.
